// File: rtl/serial_add_ctrl.sv
// Serial adder controller: one WIDTH-bit add performed nibble by nibble on a single adder_4bit.
// Optional SERIAL_ADD_OVF_EN adds a registered two's-complement overflow flag (ovf).

module adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    assign {cout, s} = 5'(a) + 5'(b) + 5'(cin);

endmodule

module serial_add_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din_one,
    input  logic [WIDTH-1:0] din_two,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef SERIAL_ADD_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int unsigned NSLICE = WIDTH / 4;
    localparam int unsigned KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] KLast = KW'(NSLICE - 1);

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
        $error("serial_add_ctrl: WIDTH must be a non-zero multiple of 4");
    end

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic [KW-1:0]    k_q;
    logic             carry_q, cout_q;
    logic [3:0]       slice_a, slice_b, slice_s;
    logic             slice_c;
    logic             last_slice;

    assign slice_a    = a_q[k_q*4 +: 4];
    assign slice_b    = b_q[k_q*4 +: 4];
    assign last_slice = (k_q == KLast);

    adder_4bit u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) state_d = StCalc;
            end
            StCalc: begin
                busy = 1'b1;
                if (last_slice) state_d = StDone;
            end
            StDone: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Operands are captured once so requester changes after accept cannot disturb the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            k_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q     <= din_one;
                        b_q     <= din_two;
                        carry_q <= cin;
                        k_q     <= '0;
                    end
                end
                StCalc: begin
                    sum_q[k_q*4 +: 4] <= slice_s;
                    carry_q           <= slice_c;
                    if (last_slice) begin
                        cout_q <= slice_c;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (state_q == StIdle && in_valid) begin
            ovf_q <= 1'b0;
        end else if (state_q == StCalc && last_slice) begin
            ovf_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_s[3] != a_q[WIDTH-1]);
        end
    end

    assign ovf = ovf_q;
`endif

endmodule
